// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
// Results are registered at the DONE transition and the done pulse follows one cycle later.
`timescale 1ns/1ps
module seq_divider #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            ready,
    output logic            done,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            div_zero
);
    localparam int CW = $clog2(DW_N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [DW_N-1:0] dvd_q, dvd_d, quo_q, quo_d;
    logic [DW_D-1:0] dvs_q, dvs_d, pr_q, pr_d, rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dz_q, dz_d, done_q;
    logic [DW_D:0]   pr_sh;
    logic [DW_D-1:0] pr_sub;
    logic            q_bit;
    logic [DW_N-1:0] dvd_nx;

    // The stored remainder is always < divisor, so after the subtract the
    // result fits in DW_D bits and the subtract can be done modulo 2^DW_D.
    always_comb begin
        pr_sh  = {pr_q, dvd_q[DW_N-1]};
        q_bit  = pr_sh[DW_D] | (pr_sh[DW_D-1:0] >= dvs_q);
        pr_sub = pr_sh[DW_D-1:0] - dvs_q;
        dvd_nx = {dvd_q[DW_N-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    pr_d  = '0;
                    cnt_d = '0;
                    if (divisor != '0) begin
                        state_d = BUSY;
                        dz_d    = 1'b0;
                    end else begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend[DW_D-1:0];
                        dz_d    = 1'b1;
                    end
                end
            end
            BUSY: begin
                // dvd_q shifts dividend bits out the top and quotient bits in the bottom
                dvd_d = dvd_nx;
                pr_d  = q_bit ? pr_sub : pr_sh[DW_D-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW_N-1)) begin
                    state_d = DONE;
                    quo_d   = dvd_nx;
                    rem_d   = q_bit ? pr_sub : pr_sh[DW_D-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= (state_q == DONE);
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, handshake/reset corner
// sequences, back-to-back spacing and a randomized sweep against q=a/b, r=a%b.
`timescale 1ns/1ps
module tb_seq_divider;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        ready, done, div_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0;

    seq_divider dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic, with the divide-by-zero convention.
    task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                           output logic [15:0] q, output logic [7:0] r, output logic dz);
        if (b == 8'd0) begin
            q = 16'hFFFF; r = a[7:0]; dz = 1'b1;
        end else begin
            q = a / 16'(b); r = 8'(a % 16'(b)); dz = 1'b0;
        end
    endtask

    // Accept one op, scramble the inputs, wait for done, then confirm the pulse ends.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        chk("ready_before_accept", 32'(ready), 32'(1));
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (done) lat = n;
        end
        if (lat == 0) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end else begin
            @(posedge clk); #1;
            chk("done_width", 32'(done), 32'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, pulses, seen, first_cyc, acc_cyc, last;
        logic [15:0] eq, a, q_seen;
        logic [7:0]  er, b, r_seen;
        logic        edz;
        int          dcyc[$];

        tbl[0]  = '{16'd990,   8'd10,  16'd99,    8'd0,   1'b0};
        tbl[1]  = '{16'd200,   8'd0,   16'hFFFF,  8'd200, 1'b1};
        tbl[2]  = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
        tbl[3]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
        tbl[4]  = '{16'd12345, 8'd0,   16'hFFFF,  8'd57,  1'b1};
        tbl[5]  = '{16'd5,     8'd9,   16'd0,     8'd5,   1'b0};
        tbl[6]  = '{16'd0,     8'd3,   16'd0,     8'd0,   1'b0};
        tbl[7]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
        tbl[8]  = '{16'd255,   8'd255, 16'd1,     8'd0,   1'b0};
        tbl[9]  = '{16'd100,   8'd200, 16'd0,     8'd100, 1'b0};
        tbl[10] = '{16'd60000, 8'd7,   16'd8571,  8'd3,   1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_quotient", 32'(quotient), 32'(0));
        chk("rst_remainder", 32'(remainder), 32'(0));
        chk("rst_div_zero", 32'(div_zero), 32'(0));
        @(negedge clk); rst = 1'b0;

        // Vector table: latency 17 normally, 1 for divide-by-zero
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, lat);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), (tbl[i].b == 0) ? 32'(1) : 32'(17));
            chk($sformatf("tbl%0d_quotient", i), 32'(quotient), 32'(tbl[i].q));
            chk($sformatf("tbl%0d_remainder", i), 32'(remainder), 32'(tbl[i].r));
            chk($sformatf("tbl%0d_div_zero", i), 32'(div_zero), 32'(tbl[i].dz));
        end

        // start during BUSY is ignored
        @(negedge clk); start = 1'b1; dividend = 16'd3267; divisor = 8'd33;
        @(posedge clk); #1; start = 1'b0;
        acc_cyc = cyc;
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; dividend = 16'd5; divisor = 8'd5;
        @(posedge clk); #1; start = 1'b0;
        pulses = 0; first_cyc = 0; q_seen = '0; r_seen = '0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin first_cyc = cyc; q_seen = quotient; r_seen = remainder; end
            end
        end
        chk("ignored_start_pulses", 32'(pulses), 32'(1));
        chk("ignored_start_latency", 32'(first_cyc - acc_cyc), 32'(17));
        chk("ignored_start_quotient", 32'(q_seen), 32'(99));
        chk("ignored_start_remainder", 32'(r_seen), 32'(0));

        // Reset in the middle of an operation
        @(negedge clk); start = 1'b1; dividend = 16'd50000; divisor = 8'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) @(posedge clk);
        #2; rst = 1'b1; #1;
        chk("midrst_quotient", 32'(quotient), 32'(0));
        chk("midrst_remainder", 32'(remainder), 32'(0));
        chk("midrst_ready", 32'(ready), 32'(1));
        chk("midrst_done", 32'(done), 32'(0));
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (done) seen++; end
        chk("midrst_no_done", 32'(seen), 32'(0));
        run_op(16'd132, 8'd4, lat);
        chk("post_rst_quotient", 32'(quotient), 32'(33));
        chk("post_rst_remainder", 32'(remainder), 32'(0));
        chk("post_rst_latency", 32'(lat), 32'(17));

        // Back-to-back with start held high: spacing DW_N+2, one-cycle pulses
        @(negedge clk); start = 1'b1; dividend = 16'd60000; divisor = 8'd7;
        last = 0;
        for (int n = 0; n < 85; n++) begin
            @(posedge clk); #1;
            if (n == 60) start = 1'b0;
            if (done) begin
                chk("b2b_adjacent_done", 32'(last), 32'(0));
                dcyc.push_back(cyc);
                chk("b2b_quotient", 32'(quotient), 32'(8571));
                chk("b2b_remainder", 32'(remainder), 32'(3));
            end
            last = int'(done);
        end
        chk("b2b_pulse_count_ge3", 32'(dcyc.size() >= 3), 32'(1));
        for (int i = 1; i < dcyc.size(); i++)
            chk("b2b_spacing", 32'(dcyc[i] - dcyc[i-1]), 32'(18));
        repeat (3) @(posedge clk);

        // Randomized sweep
        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 9))
                0: b = 8'd0;
                1: b = 8'd1;
                2: a = 16'($urandom_range(0, 255));
                default: ;
            endcase
            ref_div(a, b, eq, er, edz);
            run_op(a, b, lat);
            chk("rnd_latency", 32'(lat), (b == 0) ? 32'(1) : 32'(17));
            chk("rnd_quotient", 32'(quotient), 32'(eq));
            chk("rnd_remainder", 32'(remainder), 32'(er));
            chk("rnd_div_zero", 32'(div_zero), 32'(edz));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
